// File: rtl/uart_tx_model.sv
// Byte-buffered asynchronous serial transmitter: valid/ready push into a FIFO,
// frames sent as start bit, LSB-first payload, then one or two stop bits.
module uart_tx_model #(
   parameter int unsigned BIT_RATE     = 9600,
   parameter int unsigned CLK_HZ       = 50_000_000,
   parameter int unsigned PAYLOAD_BITS = 8,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic                               clk,
   input  logic                               resetn,
   input  logic                               wr_valid,
   input  logic [7:0]                         wr_data,
   output logic                               wr_ready,
   input  logic                               tx_en,
   output logic                               uart_txd,
   output logic                               busy,
   output logic                               frame_done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

   localparam int unsigned CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
   localparam int unsigned BIT_CNT_W      = $clog2(CYCLES_PER_BIT);
   localparam int unsigned PTR_W          = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W          = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned IDX_W          = 3;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state;
   logic [7:0]             mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       rd_ptr;
   logic [PTR_W-1:0]       wr_ptr;
   logic [7:0]             shift;
   logic [BIT_CNT_W-1:0]   bit_cnt;
   logic [IDX_W-1:0]       bit_idx;

   logic push_c;
   logic pop_c;
   logic bit_end_c;
   logic last_stop_c;
   logic stop_end_c;

   assign wr_ready    = (fifo_count != CNT_W'(FIFO_DEPTH));
   assign push_c      = wr_valid && wr_ready;
   assign bit_end_c   = (bit_cnt == BIT_CNT_W'(CYCLES_PER_BIT - 1));
   assign last_stop_c = (bit_idx == IDX_W'(STOP_BITS - 1));
   assign stop_end_c  = (state == STOP) && bit_end_c && last_stop_c;
   // A new frame may only start from idle or at the exact end of a stop period.
   assign pop_c       = tx_en && (fifo_count != '0) && ((state == IDLE) || stop_end_c);

   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push_c, pop_c})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Frame sequencer; bit_idx counts payload bits in DATA and stop bits in STOP.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         uart_txd   <= 1'b1;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         shift      <= '0;
         bit_cnt    <= '0;
         bit_idx    <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (pop_c) begin
                  shift    <= mem[rd_ptr];
                  uart_txd <= 1'b0;
                  busy     <= 1'b1;
                  bit_cnt  <= '0;
                  bit_idx  <= '0;
                  state    <= START;
               end
            end
            START: begin
               if (bit_end_c) begin
                  bit_cnt  <= '0;
                  bit_idx  <= '0;
                  uart_txd <= shift[0];
                  state    <= DATA;
               end else begin
                  bit_cnt <= bit_cnt + BIT_CNT_W'(1);
               end
            end
            DATA: begin
               if (bit_end_c) begin
                  bit_cnt <= '0;
                  if (bit_idx == IDX_W'(PAYLOAD_BITS - 1)) begin
                     uart_txd <= 1'b1;
                     bit_idx  <= '0;
                     state    <= STOP;
                  end else begin
                     shift    <= {1'b0, shift[7:1]};
                     uart_txd <= shift[1];
                     bit_idx  <= bit_idx + IDX_W'(1);
                  end
               end else begin
                  bit_cnt <= bit_cnt + BIT_CNT_W'(1);
               end
            end
            STOP: begin
               // Registered pulse lands on the final cycle of the stop period.
               if (last_stop_c && (bit_cnt == BIT_CNT_W'(CYCLES_PER_BIT - 2)))
                  frame_done <= 1'b1;
               if (bit_end_c) begin
                  bit_cnt <= '0;
                  if (last_stop_c) begin
                     bit_idx <= '0;
                     if (pop_c) begin
                        shift    <= mem[rd_ptr];
                        uart_txd <= 1'b0;
                        state    <= START;
                     end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                     end
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                  end
               end else begin
                  bit_cnt <= bit_cnt + BIT_CNT_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               uart_txd <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_model.sv
// Directed bench for uart_tx_model: 8N1 instance with a 4-deep FIFO and a 7N2
// instance, both at 10 clocks per bit.
module tb_uart_tx_model;

   localparam int CPB = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetn;
   logic       a_wr_valid, a_wr_ready, a_tx_en, a_txd, a_busy, a_frame_done;
   logic [7:0] a_wr_data;
   logic [2:0] a_count;
   logic       b_wr_valid, b_wr_ready, b_tx_en, b_txd, b_busy, b_frame_done;
   logic [7:0] b_wr_data;
   logic [4:0] b_count;

   int total = 0;
   int bad   = 0;

   logic [7:0] full_vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

   uart_tx_model #(
      .BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)
   ) u_a (
      .clk(clk), .resetn(resetn), .wr_valid(a_wr_valid), .wr_data(a_wr_data),
      .wr_ready(a_wr_ready), .tx_en(a_tx_en), .uart_txd(a_txd), .busy(a_busy),
      .frame_done(a_frame_done), .fifo_count(a_count)
   );

   uart_tx_model #(
      .BIT_RATE(100_000), .CLK_HZ(1_000_000), .PAYLOAD_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(16)
   ) u_b (
      .clk(clk), .resetn(resetn), .wr_valid(b_wr_valid), .wr_data(b_wr_data),
      .wr_ready(b_wr_ready), .tx_en(b_tx_en), .uart_txd(b_txd), .busy(b_busy),
      .frame_done(b_frame_done), .fifo_count(b_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Expected line level in frame cycle c (0-based from the pop edge).
   function automatic logic exp_txd(input logic [7:0] b, input int pb, input int c);
      int slot;
      slot = c / CPB;
      if (slot == 0) return 1'b0;
      if (slot <= pb) return b[slot-1];
      return 1'b1;
   endfunction

   // Called on cycle 1 of a frame; returns on the cycle after its last cycle.
   task automatic frame(input bit sel, input logic [7:0] b, input int pb, input int sb,
                        input int drop_at);
      int   len;
      logic txd_s, busy_s, done_s;
      len = (1 + pb + sb) * CPB;
      for (int c = 0; c < len; c++) begin
         if (c == drop_at) a_tx_en = 1'b0;
         txd_s  = sel ? b_txd : a_txd;
         busy_s = sel ? b_busy : a_busy;
         done_s = sel ? b_frame_done : a_frame_done;
         check($sformatf("txd[%0h] c%0d", b, c), 32'(txd_s), 32'(exp_txd(b, pb, c)));
         check($sformatf("busy[%0h] c%0d", b, c), 32'(busy_s), 32'(1));
         check($sformatf("frame_done[%0h] c%0d", b, c), 32'(done_s), 32'(c == len - 1));
         tick;
         a_wr_valid = 1'b0;
         b_wr_valid = 1'b0;
      end
   endtask

   task automatic check_a_idle(input string tag, input int cnt);
      check({tag, " txd"},   32'(a_txd), 32'(1));
      check({tag, " busy"},  32'(a_busy), 32'(0));
      check({tag, " done"},  32'(a_frame_done), 32'(0));
      check({tag, " count"}, 32'(a_count), 32'(cnt));
   endtask

   initial begin
      resetn = 1'b0;
      a_wr_valid = 1'b0; a_wr_data = '0; a_tx_en = 1'b0;
      b_wr_valid = 1'b0; b_wr_data = '0; b_tx_en = 1'b0;
      repeat (2) tick;
      check_a_idle("reset", 0);
      check("reset wr_ready", 32'(a_wr_ready), 32'(1));
      check("reset b txd", 32'(b_txd), 32'(1));
      check("reset b wr_ready", 32'(b_wr_ready), 32'(1));
      check("reset b count", 32'(b_count), 32'(0));
      resetn = 1'b1;
      tick;

      // 7 data bits, 2 stop bits; bit 7 of wr_data is dropped
      b_tx_en = 1'b1;
      b_wr_valid = 1'b1; b_wr_data = 8'hFF;
      tick;
      b_wr_data = 8'hAA;
      tick;
      b_wr_valid = 1'b0;
      check("7n2 count", 32'(b_count), 32'(1));
      frame(1'b1, 8'hFF, 7, 2, -1);
      frame(1'b1, 8'hAA, 7, 2, -1);
      check("7n2 idle txd", 32'(b_txd), 32'(1));
      check("7n2 idle busy", 32'(b_busy), 32'(0));
      check("7n2 idle count", 32'(b_count), 32'(0));

      // Single byte, no bypass: pop happens one edge after the push
      a_tx_en = 1'b1;
      a_wr_valid = 1'b1; a_wr_data = 8'h41;
      tick;
      a_wr_valid = 1'b0;
      check_a_idle("after push", 1);
      tick;
      check("after pop count", 32'(a_count), 32'(0));
      frame(1'b0, 8'h41, 8, 1, -1);
      check_a_idle("single end", 0);

      // "HI\n" back-to-back
      a_wr_valid = 1'b1; a_wr_data = 8'h48;
      tick;
      a_wr_data = 8'h49;
      tick;
      a_wr_data = 8'h0A;
      frame(1'b0, 8'h48, 8, 1, -1);
      check("b2b count1", 32'(a_count), 32'(1));
      frame(1'b0, 8'h49, 8, 1, -1);
      check("b2b count2", 32'(a_count), 32'(0));
      frame(1'b0, 8'h0A, 8, 1, -1);
      check_a_idle("b2b end", 0);

      // Full FIFO with tx_en low; fifth push refused
      a_tx_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a_wr_valid = 1'b1; a_wr_data = full_vals[i];
         check($sformatf("full wr_ready %0d", i), 32'(a_wr_ready), 32'(i < 4));
         tick;
      end
      a_wr_valid = 1'b0;
      check_a_idle("full held", 4);
      check("full wr_ready", 32'(a_wr_ready), 32'(0));
      a_tx_en = 1'b1;
      tick;
      check("full first pop count", 32'(a_count), 32'(3));
      check("full first pop wr_ready", 32'(a_wr_ready), 32'(1));
      for (int i = 0; i < 4; i++) frame(1'b0, full_vals[i], 8, 1, -1);
      check_a_idle("full end", 0);

      // tx_en dropped mid-frame with 2 bytes queued
      a_tx_en = 1'b0;
      a_wr_valid = 1'b1; a_wr_data = 8'h5A;
      tick;
      a_wr_data = 8'hA5;
      tick;
      a_wr_valid = 1'b0;
      check("drop queued", 32'(a_count), 32'(2));
      a_tx_en = 1'b1;
      tick;
      frame(1'b0, 8'h5A, 8, 1, 50);
      check_a_idle("drop end", 1);
      for (int i = 0; i < 30; i++) begin
         tick;
         check($sformatf("drop hold txd %0d", i), 32'(a_txd), 32'(1));
      end
      check_a_idle("drop hold", 1);

      // Reset in the middle of the data bits
      a_tx_en = 1'b1;
      tick;
      check("rst pre busy", 32'(a_busy), 32'(1));
      repeat (30) tick;
      #2 resetn = 1'b0;
      #1;
      check_a_idle("rst async", 0);
      check("rst wr_ready", 32'(a_wr_ready), 32'(1));
      tick;
      resetn = 1'b1;
      tick;
      check_a_idle("rst released", 0);
      a_wr_valid = 1'b1; a_wr_data = 8'h3C;
      tick;
      a_wr_valid = 1'b0;
      tick;
      frame(1'b0, 8'h3C, 8, 1, -1);
      check_a_idle("post rst end", 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
